conware_multigen: RTL and testbench
===================================

// Module: conware_multigen
// PURPOSE
//  Next-generation Game-of-Life frame engine. Takes in one WIDTH x HEIGHT frame of colour pixels on AXI-Stream.
//  Runs a runtime-selected number of Life generations on it, then streams the result back out as colours.
//  Adds what the single-step engine lacks:
//  - N generations per frame, computed one generation per cycle.
//  - Selectable toroidal or dead-border edges.
//  - Frame-length error handling.
//  - Status outputs.
//  Sits between the VDMA read and write channels of the display pipeline.
// PARAMETERS
//  DWIDTH  32  pixel/TDATA width in bits
//  WIDTH    8  grid columns (>=3)
//  HEIGHT   8  grid rows (>=3)
//  GEN_W    8  width of the generations count
// PORTS
//  clk            in   1       clock, all logic on its rising edge
//  rst            in   1       synchronous reset, active-high
//  alive_color    in   DWIDTH  colour meaning "alive"
//  dead_color     in   DWIDTH  colour emitted for dead cells
//  generations    in   GEN_W   generations to run on the next frame (G)
//  wrap_en        in   1       1 = toroidal edges, 0 = off-grid neighbours are dead
//  S_AXIS_TVALID  in   1       input stream valid
//  S_AXIS_TREADY  out  1       input stream ready
//  S_AXIS_TDATA   in   DWIDTH  input pixel
//  S_AXIS_TLAST   in   1       input end of frame
//  M_AXIS_TVALID  out  1       output stream valid
//  M_AXIS_TREADY  in   1       output stream ready
//  M_AXIS_TDATA   out  DWIDTH  output pixel
//  M_AXIS_TLAST   out  1       output end of frame (pixel WIDTH*HEIGHT-1)
//  busy           out  1       high in COMPUTE and OUT
//  frame_err      out  1       1-cycle pulse on a malformed input frame
//  frame_done     out  1       1-cycle pulse on the last output handshake
// BEHAVIOUR
//  Reset (rst=1 at a clk edge), overriding everything incl. mid-frame:
//   - state=LOAD; grid, pixel and generation counters cleared.
//   - S_AXIS_TREADY=1; M_AXIS_TVALID/TLAST/TDATA, busy, frame_err, frame_done all = 0.
//  Grid layout: pixel k of a frame is cell x=k%WIDTH, y=k/WIDTH, row-major; k=0 is top-left.
//   A cell is alive iff its pixel == latched alive_color exactly.
//  Latching: on the first input handshake of a frame, latch alive_color, dead_color, generations and wrap_en.
//   Port changes mid-frame have no effect on that frame.
//  Life rule:
//   - Live cell survives with 2 or 3 live neighbours of its 8.
//   - Dead cell is born with exactly 3.
//   - All cells update simultaneously.
//   - wrap_en=1: neighbour coordinates taken mod WIDTH/HEIGHT. wrap_en=0: out-of-grid neighbours count as dead.
//  Neighbour count is 4 bits; no saturation needed (max 8).
//  States:
//   - LOAD: TREADY=1. Each handshake writes cell k and increments k.
//     - Beat k=W*H-1 with TLAST=1 -> COMPUTE (G>0) or OUT (G=0).
//     - TLAST=1 at k<W*H-1 (short frame): cells k+1..W*H-1 forced dead, frame_err pulses, proceed as if complete.
//     - Beat k=W*H-1 with TLAST=0 (long frame): frame_err pulses -> FLUSH.
//   - FLUSH: TREADY=1. Beats are discarded until a TLAST handshake, then -> COMPUTE/OUT as above.
//   - COMPUTE: TREADY=0. One generation is applied per cycle; after exactly G cycles -> OUT.
//   - OUT: TREADY=0, TVALID=1.
//     - TDATA = latched alive/dead colour of cell j; TLAST=1 only at j=W*H-1.
//     - j advances only on the TVALID&TREADY handshake; TDATA/TLAST are held stable while TREADY=0.
//     - Last handshake: frame_done pulses next cycle, state -> LOAD, TVALID=0.
//  Latency: first M_AXIS_TVALID rises exactly G+1 cycles after the last input handshake (FLUSH adds its drop time).
//  Throughput: 1 beat/cycle in and out under no backpressure.
//  No input/output overlap: the next frame is not accepted until the current output completes.
//  G=0 is pure colour requantisation: non-alive pixels become dead_color.
//  G=2^GEN_W-1 is legal; the counter must not wrap early.
// TESTING
//  - W=H=4, G=1, wrap=0, alive at k=4,5,6 -> out alive k=1,5,9 only; TLAST on beat 15; TVALID 2 cycles after in-TLAST.
//  - Same frame, G=2 -> alive k=4,5,6 (period-2 blinker); G=0 -> input echoed; stray colour 0x123 -> dead_color.
//  - Alive k=7,4,5: wrap=1, G=1 -> alive k=0,4,8. Same frame with wrap=0 -> all 16 dead.
//  - Short frame: TLAST on beat 9 -> frame_err pulse, cells 10..15 dead, output still 16 beats.
//  - Long frame: 20 beats, TLAST on beat 19 -> frame_err at beat 15, beats 16-19 dropped, output 16 beats.
//  - Random M_AXIS_TREADY at 30% -> TDATA stable under stall, 16 beats in order.
//  - rst asserted mid-OUT -> next cycle TVALID=0, TREADY=1, and a fresh frame processes correctly.

Source files
------------

// File: rtl/conware_multigen.sv
// conware_multigen: multi-generation Game-of-Life frame engine between AXI-Stream pixel ports
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   alive_color, dead_color     colour that marks a live cell / colour emitted for dead cells
//   generations, wrap_en        generation count and toroidal-edge select
//                               (these and the colours are latched on a frame's first input beat)
//   S_AXIS_TVALID/TREADY/TDATA/TLAST   pixel input, row-major, k=0 top-left
//   M_AXIS_TVALID/TREADY/TDATA/TLAST   colour output after G generations
//   busy                        high while computing or streaming out
//   frame_err                   1-cycle pulse on a short or long input frame
//   frame_done                  1-cycle pulse after the last output handshake
module conware_multigen #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] alive_color,
    input  logic [DWIDTH-1:0] dead_color,
    input  logic [GEN_W-1:0]  generations,
    input  logic              wrap_en,
    input  logic              S_AXIS_TVALID,
    output logic              S_AXIS_TREADY,
    input  logic [DWIDTH-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic [DWIDTH-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    output logic              busy,
    output logic              frame_err,
    output logic              frame_done
);
    localparam int N = WIDTH * HEIGHT;
    localparam int K_W = $clog2(N);
    localparam logic [K_W-1:0] LAST = K_W'(N - 1);

    typedef enum logic [1:0] {LOAD, FLUSH, COMPUTE, OUT} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      grid_q, grid_d, life;
    logic [K_W-1:0]    k_q, k_d, j_q, j_d;
    logic [GEN_W-1:0]  gen_q, gen_d, gen_cur;
    logic [DWIDTH-1:0] alive_q, alive_d, dead_q, dead_d, alive_cur;
    logic              wrap_q, wrap_d, err_q, err_d, done_q, done_d;
    logic              first, hs_in, hs_out;

    assign S_AXIS_TREADY = state_q == LOAD || state_q == FLUSH;
    assign M_AXIS_TVALID = state_q == OUT;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && j_q == LAST;
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? (grid_q[j_q] ? alive_q : dead_q) : '0;
    assign busy          = state_q == COMPUTE || state_q == OUT;
    assign frame_err     = err_q;
    assign frame_done    = done_q;
    assign hs_in         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign hs_out        = M_AXIS_TVALID && M_AXIS_TREADY;
    // The first beat of a frame must already see this frame's colour and count.
    assign first         = state_q == LOAD && k_q == '0;
    assign alive_cur     = first ? alive_color : alive_q;
    assign gen_cur       = first ? generations : gen_q;

    for (genvar y = 0; y < HEIGHT; y++) begin : g_row
        for (genvar x = 0; x < WIDTH; x++) begin : g_col
            localparam int XL = (x + WIDTH - 1) % WIDTH;
            localparam int XR = (x + 1) % WIDTH;
            localparam int YU = (y + HEIGHT - 1) % HEIGHT;
            localparam int YD = (y + 1) % HEIGHT;
            // Edge neighbours reached only by wrapping are masked off unless wrap is latched.
            logic       l_ok, r_ok, u_ok, d_ok;
            logic [7:0] nb;
            logic [3:0] cnt;
            assign l_ok = wrap_q || (x > 0);
            assign r_ok = wrap_q || (x < WIDTH - 1);
            assign u_ok = wrap_q || (y > 0);
            assign d_ok = wrap_q || (y < HEIGHT - 1);
            assign nb = {grid_q[YU*WIDTH+XL] & u_ok & l_ok, grid_q[YU*WIDTH+x] & u_ok,
                         grid_q[YU*WIDTH+XR] & u_ok & r_ok, grid_q[y*WIDTH+XL] & l_ok,
                         grid_q[y*WIDTH+XR] & r_ok,         grid_q[YD*WIDTH+XL] & d_ok & l_ok,
                         grid_q[YD*WIDTH+x] & d_ok,         grid_q[YD*WIDTH+XR] & d_ok & r_ok};
            assign cnt = 4'($countones(nb));
            assign life[y*WIDTH+x] = cnt == 4'd3 || (grid_q[y*WIDTH+x] && cnt == 4'd2);
        end
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        k_d     = k_q;
        j_d     = j_q;
        gen_d   = gen_q;
        alive_d = alive_q;
        dead_d  = dead_q;
        wrap_d  = wrap_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        // Clearing the grid at frame start leaves cells past a short frame dead.
        if (hs_in && first) begin
            alive_d = alive_color;
            dead_d  = dead_color;
            gen_d   = generations;
            wrap_d  = wrap_en;
            grid_d  = '0;
        end
        if (hs_in && state_q == LOAD) begin
            grid_d[k_q] = S_AXIS_TDATA == alive_cur;
            k_d         = (S_AXIS_TLAST || k_q == LAST) ? '0 : k_q + 1'b1;
            err_d       = S_AXIS_TLAST != (k_q == LAST);
            if (k_q == LAST && !S_AXIS_TLAST) state_d = FLUSH;
        end
        if (hs_in && S_AXIS_TLAST) state_d = gen_cur != '0 ? COMPUTE : OUT;
        if (state_q == COMPUTE) begin
            grid_d = life;
            gen_d  = gen_q - 1'b1;
            if (gen_q == GEN_W'(1)) state_d = OUT;
        end
        if (hs_out) begin
            j_d = j_q == LAST ? '0 : j_q + 1'b1;
            if (j_q == LAST) begin
                done_d  = 1'b1;
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            grid_q  <= '0;
            k_q     <= '0;
            j_q     <= '0;
            gen_q   <= '0;
            alive_q <= '0;
            dead_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            k_q     <= k_d;
            j_q     <= j_d;
            gen_q   <= gen_d;
            alive_q <= alive_d;
            dead_q  <= dead_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_conware_multigen.sv
// tb_conware_multigen: directed and random frames checked against a grid-level Life model
module tb_conware_multigen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alive_color, dead_color, s_tdata, m_tdata;
    logic [7:0]  generations;
    logic        wrap_en, s_tvalid, s_tready, s_tlast;
    logic        m_tvalid, m_tready, m_tlast, busy, frame_err, frame_done;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] px[$];
    logic [31:0] ac, dc;
    logic [31:0] exp_col[N];

    conware_multigen #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H), .GEN_W(8)) dut (
        .clk(clk), .rst(rst), .alive_color(alive_color), .dead_color(dead_color),
        .generations(generations), .wrap_en(wrap_en),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TLAST(s_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .busy(busy),
        .frame_err(frame_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic fill(input int a0, input int a1, input int a2, input int len);
        px.delete();
        for (int k = 0; k < len; k++) px.push_back((k == a0 || k == a1 || k == a2) ? ac : dc);
    endtask

    // Plain Life on a W x H board: cells from the first N beats, absent beats are dead.
    task automatic build_expect(input int g, input bit wr);
        bit cur[N];
        bit nxt[N];
        for (int k = 0; k < N; k++) cur[k] = (k < px.size()) && (px[k] == ac);
        repeat (g) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    int n;
                    n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            int xx;
                            int yy;
                            xx = x + dx;
                            yy = y + dy;
                            if (dx == 0 && dy == 0) continue;
                            if (wr) begin
                                xx = (xx + W) % W;
                                yy = (yy + H) % H;
                            end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
                            n += int'(cur[yy*W+xx]);
                        end
                    end
                    nxt[y*W+x] = cur[y*W+x] ? (n == 2 || n == 3) : (n == 3);
                end
            end
            cur = nxt;
        end
        for (int k = 0; k < N; k++) exp_col[k] = cur[k] ? ac : dc;
    endtask

    task automatic send(input int g, input bit wr, input int err_at);
        int i = 0;
        int errs = 0;
        int seen = -1;
        int n = 1;
        int guard = 0;
        bit hs;
        generations = 8'(g);
        wrap_en = wr;
        alive_color = ac;
        dead_color = dc;
        while (i < px.size() && guard < 1000) begin
            s_tvalid = 1'b1;
            s_tdata = px[i];
            s_tlast = (i == px.size() - 1);
            hs = s_tready;
            @(posedge clk); #1;
            guard++;
            if (frame_err) begin
                errs++;
                seen = i;
            end
            if (hs) begin
                i++;
                alive_color = ~ac;
                dead_color = ~dc;
                generations = 8'($urandom);
                wrap_en = ~wr;
            end
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        check("in_guard", guard < 1000, 1);
        while (!m_tvalid && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (frame_err) errs++;
        end
        check("latency", n, g + 1);
        check("busy_out", busy, 1);
        check("tready_out", s_tready, 0);
        check("err_count", errs, err_at >= 0);
        if (err_at >= 0) check("err_beat", seen, err_at);
    endtask

    task automatic recv(input int max_beats, input int pct);
        int j = 0;
        int cyc = 0;
        bit stall = 1'b0;
        bit v;
        bit r;
        logic [31:0] pd;
        logic pl;
        while (j < max_beats && cyc < 3000) begin
            if (stall) begin
                check("stall_data", m_tdata, pd);
                check("stall_last", m_tlast, pl);
            end
            m_tready = ($urandom_range(0, 99) < pct);
            pd = m_tdata;
            pl = m_tlast;
            v = m_tvalid;
            r = m_tready;
            @(posedge clk); #1;
            cyc++;
            if (v && r) begin
                check($sformatf("data%0d", j), pd, exp_col[j]);
                check($sformatf("last%0d", j), pl, j == N - 1);
                j++;
                stall = 1'b0;
            end else stall = v;
        end
        m_tready = 1'b0;
        check("out_beats", j, max_beats);
        if (pct >= 100) check("throughput", cyc, max_beats);
        if (j == N) begin
            check("done_pulse", frame_done, 1);
            check("tvalid_low", m_tvalid, 0);
            check("tready_back", s_tready, 1);
            check("busy_low", busy, 0);
            @(posedge clk); #1;
            check("done_once", frame_done, 0);
        end
    endtask

    initial begin
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        m_tready = 1'b0;
        alive_color = '0;
        dead_color = '0;
        generations = '0;
        wrap_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", s_tready, 1);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        ac = 32'h00FF_FFFF;
        dc = 32'h1111_1111;
        fill(4, 5, 6, 16); build_expect(1, 0); send(1, 0, -1); recv(16, 100);
        fill(4, 5, 6, 16); build_expect(2, 0); send(2, 0, -1); recv(16, 100);
        fill(4, 5, 6, 16); px[0] = 32'h123; build_expect(0, 0); send(0, 0, -1); recv(16, 30);
        fill(7, 4, 5, 16); build_expect(1, 1); send(1, 1, -1); recv(16, 100);
        fill(7, 4, 5, 16); build_expect(1, 0); send(1, 0, -1); recv(16, 30);
        fill(4, 5, 6, 10); build_expect(1, 0); send(1, 0, 9); recv(16, 100);
        fill(4, 5, 6, 20);
        for (int k = 16; k < 20; k++) px[k] = $urandom;
        build_expect(1, 0); send(1, 0, 15); recv(16, 30);
        repeat (6) begin
            int g;
            bit wr;
            ac = $urandom;
            dc = ac ^ 32'h0000_0F0F;
            px.delete();
            for (int k = 0; k < N; k++)
                px.push_back($urandom_range(0, 1) ? ac : ($urandom_range(0, 3) == 0 ? $urandom : dc));
            g = $urandom_range(0, 6);
            wr = 1'($urandom_range(0, 1));
            build_expect(g, wr); send(g, wr, -1); recv(16, 30);
        end
        ac = 32'hCAFE_0001;
        dc = 32'h0000_0002;
        fill(4, 5, 6, 16); build_expect(255, 1); send(255, 1, -1); recv(16, 100);
        fill(4, 5, 6, 16); build_expect(1, 0); send(1, 0, -1); recv(5, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tvalid", m_tvalid, 0);
        check("mid_rst_tready", s_tready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tdata", m_tdata, 0);
        rst = 1'b0;
        fill(7, 4, 5, 16); build_expect(1, 1); send(1, 1, -1); recv(16, 30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
